// File: rtl/mem_seq_pkg.sv
// Shared definitions for the LC-3 memory sequencer.
//   state_e       : sequencer FSM state encoding
//   word_t        : 16-bit CPU data/address word
//   IoAddrDefault : default memory-mapped I/O address
//   SramAddrW     : external SRAM address width
package mem_seq_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StWrHold,
        StAck,
        StWaitRel
    } state_e;

    localparam word_t       IoAddrDefault = 16'hFFFF;
    localparam int unsigned SramAddrW     = 20;

endpackage

// File: rtl/mem_sequencer_if.sv
// CPU-side memory handshake between the LC-3 control unit and mem_sequencer.
//   Mem_OE, Mem_WE : level-held read/write requests
//   MAR, MDR       : access address and write data
//   Data_to_CPU    : registered read data
//   Mem_Ready      : one-cycle completion pulse
//   Busy           : sequencer not idle
// master = CPU side, slave = sequencer side.
interface mem_sequencer_if;
    import mem_seq_pkg::*;

    logic  Mem_OE;
    logic  Mem_WE;
    word_t MAR;
    word_t MDR;
    word_t Data_to_CPU;
    logic  Mem_Ready;
    logic  Busy;

    modport master (
        output Mem_OE, Mem_WE, MAR, MDR,
        input  Data_to_CPU, Mem_Ready, Busy
    );

    modport slave (
        input  Mem_OE, Mem_WE, MAR, MDR,
        output Data_to_CPU, Mem_Ready, Busy
    );

endinterface

// File: rtl/mem_sequencer.sv
// Memory-access sequencer: turns level-held CPU read/write requests into
// async SRAM cycles with WAIT_STATES extra strobe cycles, maps IO_ADDR to the
// switch inputs (read) and the hex display register (write), and reports
// completion with a one-cycle Mem_Ready pulse.
// Ports:
//   Clk, Reset_n : clock, async active-low reset
//   bus          : CPU handshake (slave modport)
//   SW           : switch inputs, read at IO_ADDR
//   HEX_Data     : display register, written at IO_ADDR
//   SRAM_*       : external SRAM address, data and active-low strobes
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter word_t       IO_ADDR     = IoAddrDefault
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    mem_sequencer_if.slave       bus,
    input  word_t                SW,
    output word_t                HEX_Data,
    output logic [SramAddrW-1:0] SRAM_ADDR,
    inout  wire  [15:0]          SRAM_DQ,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    localparam int unsigned CntW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(WAIT_STATES);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    word_t           addr_q;
    word_t           wdata_q;
    word_t           rdata_q;
    word_t           hex_q;
    logic            ready_q;
    logic            busy_q;
    logic            dq_oe_q;
    logic            ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;

    // Strobes and DQ enable are registered alongside the state they belong to,
    // so the async reset releases them together with the state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Write wins when both requests are high.
                    if (bus.Mem_WE) begin
                        busy_q <= 1'b1;
                        if (bus.MAR == IO_ADDR) begin
                            hex_q   <= bus.MDR;
                            ready_q <= 1'b1;
                            state_q <= StAck;
                        end else begin
                            addr_q  <= bus.MAR;
                            wdata_q <= bus.MDR;
                            cnt_q   <= '0;
                            ce_n_q  <= 1'b0;
                            we_n_q  <= 1'b0;
                            ub_n_q  <= 1'b0;
                            lb_n_q  <= 1'b0;
                            dq_oe_q <= 1'b1;
                            state_q <= StWr;
                        end
                    end else if (bus.Mem_OE) begin
                        busy_q <= 1'b1;
                        if (bus.MAR == IO_ADDR) begin
                            rdata_q <= SW;
                            ready_q <= 1'b1;
                            state_q <= StAck;
                        end else begin
                            addr_q  <= bus.MAR;
                            cnt_q   <= '0;
                            ce_n_q  <= 1'b0;
                            oe_n_q  <= 1'b0;
                            ub_n_q  <= 1'b0;
                            lb_n_q  <= 1'b0;
                            state_q <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (cnt_q == CntMax) begin
                        rdata_q <= SRAM_DQ;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        ub_n_q  <= 1'b1;
                        lb_n_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWr: begin
                    if (cnt_q == CntMax) begin
                        we_n_q  <= 1'b1;
                        state_q <= StWrHold;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWrHold: begin
                    // WE_N already high; keep CE_N and data one more cycle for hold time.
                    ce_n_q  <= 1'b1;
                    ub_n_q  <= 1'b1;
                    lb_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StAck;
                end
                StAck: begin
                    state_q <= StWaitRel;
                end
                StWaitRel: begin
                    if (!bus.Mem_OE && !bus.Mem_WE) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign SRAM_DQ         = dq_oe_q ? wdata_q : 16'hzzzz;
    assign SRAM_ADDR       = {4'b0, addr_q};
    assign SRAM_CE_N       = ce_n_q;
    assign SRAM_OE_N       = oe_n_q;
    assign SRAM_WE_N       = we_n_q;
    assign SRAM_UB_N       = ub_n_q;
    assign SRAM_LB_N       = lb_n_q;
    assign HEX_Data        = hex_q;
    assign bus.Data_to_CPU = rdata_q;
    assign bus.Mem_Ready   = ready_q;
    assign bus.Busy        = busy_q;

endmodule
